// File: rtl/dds_wave_ctrl.sv
// dds_wave_ctrl
//   Control stage in front of the single-port waveform RAM of the DDS.
//   It loads a complete waveform table through a valid/ready stream. After
//   that it plays the table back. A phase accumulator produces one RAM read
//   address per cycle, and the returned samples become the output stream.
//
// Handshake: a load sample transfers on any rising edge where
//   ld_valid && ld_ready. ld_ready depends only on the FSM state (high in
//   LOAD), so it never depends combinationally on ld_valid.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   load_start               pulse, starts a table load (IDLE or RUN)
//   ld_valid/ld_ready/ld_data  load sample stream
//   load_done                one-cycle pulse once the last write has committed
//   run_en                   level, enables playback
//   freq_word, phase_off     phase increment / offset, sampled each RUN cycle
//   ram_wea/ram_addr/ram_wr_data  registered RAM controls
//   ram_re_data              RAM read data, RD_LAT cycles after ram_addr
//   dout, dout_valid         output sample stream
//   dbg_state                current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 RUN)
module dds_wave_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 256,
  parameter int PHASE_W    = 32,
  parameter int RD_LAT     = 2,
  localparam int ADDR_W    = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  load_done,
  input  logic                  run_en,
  input  logic [PHASE_W-1:0]    freq_word,
  input  logic [PHASE_W-1:0]    phase_off,
  output logic                  ram_wea,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_re_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [1:0]            dbg_state
);

  localparam int SHIFT = PHASE_W - ADDR_W;
  localparam int DR_W  = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [DR_W-1:0]       drain_q, drain_d;
  logic [PHASE_W-1:0]    acc_q, acc_d;
  logic                  wea_q, wea_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  load_done_q, load_done_d;
  logic [RD_LAT:0]       tag_q, tag_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  issue;
  logic                  flush;
  logic [PHASE_W-1:0]    rd_phase;

  // Read phase: accumulator plus offset, wrapping modulo 2^PHASE_W.
  assign rd_phase = acc_q + phase_off;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    acc_d       = acc_q;
    wea_d       = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    load_done_d = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (run_en) begin
          // The entry edge acts as the first playback step, taken from
          // acc = 0. The first address is therefore the top bits of
          // phase_off, and the accumulator moves on to 0 + freq_word.
          state_d = S_RUN;
          acc_d   = freq_word;
          addr_d  = ADDR_W'(phase_off >> SHIFT);
          issue   = 1'b1;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          wea_d     = 1'b1;
          addr_d    = cnt_d;
          wr_data_d = ld_data;
          cnt_d     = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DATA_DEPTH - 1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        // Hold off until the RAM's input-registered write has landed.
        if (drain_q == DR_W'(RD_LAT)) begin
          state_d     = S_IDLE;
          drain_d     = '0;
          load_done_d = 1'b1;
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          flush   = 1'b1;
        end else if (!run_en) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else begin
          acc_d  = acc_q + freq_word;
          addr_d = ADDR_W'(rd_phase >> SHIFT);
          issue  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read pipeline. tag_q[RD_LAT] lines up with ram_re_data for the address
  // issued RD_LAT cycles earlier. Leaving RUN drops every sample still in
  // flight, and dout keeps its last value.
  always_comb begin
    tag_d        = '0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (!flush) begin
      tag_d        = {tag_q[RD_LAT-1:0], issue};
      dout_valid_d = tag_q[RD_LAT];
      if (tag_q[RD_LAT]) dout_d = ram_re_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      acc_q        <= '0;
      wea_q        <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      load_done_q  <= 1'b0;
      tag_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      acc_q        <= acc_d;
      wea_q        <= wea_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      load_done_q  <= load_done_d;
      tag_q        <= tag_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign ld_ready    = (state_q == S_LOAD);
  assign load_done   = load_done_q;
  assign ram_wea     = wea_q;
  assign ram_addr    = addr_q;
  assign ram_wr_data = wr_data_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Bench for dds_wave_ctrl with a behavioural input/output-registered RAM.
module tb_dds_wave_ctrl;

  localparam int DW     = 8;
  localparam int DEPTH  = 256;
  localparam int PW     = 32;
  localparam int RD_LAT = 2;
  localparam int AW     = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          load_start, ld_valid, ld_ready, load_done, run_en;
  logic [DW-1:0] ld_data;
  logic [PW-1:0] freq_word, phase_off;
  logic          ram_wea;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_re_data, dout;
  logic          dout_valid;
  logic [1:0]    dbg_state;

  dds_wave_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .PHASE_W(PW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .load_done(load_done),
    .run_en(run_en), .freq_word(freq_word), .phase_off(phase_off),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_re_data(ram_re_data), .dout(dout), .dout_valid(dout_valid),
    .dbg_state(dbg_state)
  );

  // RAM model: inputs registered, then the output registered.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] rd_q;
  logic          rw_q;
  always @(posedge clk) begin
    ra_q <= ram_addr;
    rw_q <= ram_wea;
    rd_q <= ram_wr_data;
    if (rw_q === 1'b1) mem[ra_q] <= rd_q;
    ram_re_data <= mem[ra_q];
  end

  // Table contents the bench expects the RAM to hold.
  logic [DW-1:0] tbl [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      tbl[i] = '0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0]   wexp_q[$];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write and every output sample pops one expectation.
  always @(negedge clk) begin
    if (ram_wea === 1'b1) begin
      if (wexp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", ram_addr, ram_wr_data);
      end else begin
        check("ram_write", {ram_addr, ram_wr_data}, wexp_q.pop_front());
      end
    end
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dout_unexpected: got %0h expected no sample", dout);
      end else begin
        check("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] pat(input int sel, input int i);
    logic [DW-1:0] v;
    v = DW'(i);
    case (sel)
      1:       pat = v ^ 8'h5A;
      2:       pat = ~v;
      default: pat = v;
    endcase
  endfunction

  task automatic check_reset(input string name);
    check({name, "_ld_ready"}, ld_ready, 0);
    check({name, "_load_done"}, load_done, 0);
    check({name, "_wea"}, ram_wea, 0);
    check({name, "_addr"}, ram_addr, 0);
    check({name, "_wr_data"}, ram_wr_data, 0);
    check({name, "_dout"}, dout, 0);
    check({name, "_dout_valid"}, dout_valid, 0);
    check({name, "_state"}, dbg_state, 0);
  endtask

  // Called at a negedge while the DUT sits in IDLE.
  task automatic load_begin();
    check("ld_ready_idle", ld_ready, 0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("ld_ready_rise", ld_ready, 1);
    check("state_load", dbg_state, 1);
  endtask

  // Streams DEPTH beats (a gap cycle between beats if gap). When abort_at
  // >= 0, reset is asserted in place of that beat.
  task automatic load_body(input bit gap, input int sel, input int abort_at);
    logic [DW-1:0] d;
    int  lat;
    bit  seen;
    for (int i = 0; i < DEPTH; i++) begin
      d = pat(sel, i);
      ld_valid = 1'b1;
      ld_data  = d;
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        ld_valid = 1'b0;
        check_reset("rst_mid_load");
        seen = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (load_done) seen = 1'b1;
        end
        check("no_load_done_after_rst", seen, 0);
        check("state_idle_after_rst", dbg_state, 0);
        return;
      end
      wexp_q.push_back({AW'(i), d});
      tbl[i] = d;
      @(negedge clk);
      if (gap && i != DEPTH - 1) begin
        ld_valid = 1'b0;
        ld_data  = DW'($urandom_range(0, 255));
        check("ld_ready_gap", ld_ready, 1);
        @(negedge clk);
      end
    end
    ld_valid = 1'b0;
    check("ld_ready_fall", ld_ready, 0);
    check("last_wea", ram_wea, 1);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (load_done) lat = c;
    end
    check("load_done_lat", lat, RD_LAT + 1);
    @(negedge clk);
    check("load_done_pulse", load_done, 0);
    check("state_idle_after_load", dbg_state, 0);
    check("writes_all_seen", wexp_q.size(), 0);
  endtask

  // Plays for k rising edges with run_en high, then leaves RUN either by
  // dropping run_en or by a load_start (DUT then stays in LOAD).
  task automatic run_for(input int k, input logic [31:0] fw, input logic [31:0] po, input bit to_load);
    logic [31:0]   acc;
    logic [DW-1:0] last;
    int first_n, nvalid;
    acc  = '0;
    last = '0;
    for (int j = 0; j < k - RD_LAT - 1; j++) begin
      last = tbl[AW'((acc + po) >> (PW - AW))];
      exp_q.push_back(last);
      acc = acc + fw;
    end
    freq_word = fw;
    phase_off = po;
    run_en    = 1'b1;
    first_n   = 0;
    nvalid    = 0;
    for (int n = 1; n <= k; n++) begin
      @(negedge clk);
      if (n == 1) check("state_run", dbg_state, 3);
      if (dout_valid) begin
        nvalid++;
        if (first_n == 0) first_n = n;
      end
      if (n == k) begin
        if (to_load) load_start = 1'b1;
        else run_en = 1'b0;
      end
    end
    check("first_valid_cycle", first_n, RD_LAT + 2);
    check("valid_count", nvalid, k - RD_LAT - 1);
    @(negedge clk);
    check("dout_valid_drop", dout_valid, 0);
    check("dout_hold", dout, last);
    check("samples_all_seen", exp_q.size(), 0);
    if (to_load) begin
      load_start = 1'b0;
      run_en     = 1'b0;
      check("ld_ready_from_run", ld_ready, 1);
      check("state_load_from_run", dbg_state, 1);
    end else begin
      check("state_idle_after_run", dbg_state, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    run_en     = 1'b0;
    freq_word  = '0;
    phase_off  = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Playback before any load reads the zeroed RAM.
    run_for(6, 32'h0100_0000, 32'h0, 1'b0);

    // Ramp load, ld_valid held high.
    load_begin();
    load_body(1'b0, 0, -1);

    // Ramp playback: 0..255 then wraps to 0.
    run_for(260, 32'h0100_0000, 32'h0, 1'b0);
    // Re-enable restarts from accumulator 0.
    run_for(10, 32'h0100_0000, 32'h0, 1'b0);
    // Half-rate: 0,128,... and with quarter offset 64,192,...; abort via load.
    run_for(12, 32'h8000_0000, 32'h0, 1'b0);
    run_for(12, 32'h8000_0000, 32'h4000_0000, 1'b1);

    // Load with ld_valid toggling, then odd step/offset playback.
    load_body(1'b1, 1, -1);
    run_for(8, 32'h0300_0000, 32'h0500_0000, 1'b0);

    // Reset at beat 100, then a full load completes normally.
    load_begin();
    load_body(1'b0, 2, 100);
    check("writes_before_rst_seen", wexp_q.size(), 0);
    load_begin();
    load_body(1'b0, 0, -1);
    run_for(8, 32'h0100_0000, 32'h8000_0000, 1'b0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
